// File: rtl/sc_reg_bank_pkg.sv
// Shared register-code map and width defaults for the register bank, source
// multiplexer and control unit.
package sc_reg_bank_pkg;

  localparam int DEF_DATAWIDTH_BUS           = 32;
  localparam int DEF_DATAWIDTH_REG_SELECTION = 4;
  localparam logic [31:0] DEF_PC_RESET_VALUE = 32'h0000_0000;

  typedef logic [3:0] reg_code_t;

  localparam reg_code_t REG_G0    = 4'b0000;
  localparam reg_code_t REG_G1    = 4'b0001;
  localparam reg_code_t REG_G2    = 4'b0010;
  localparam reg_code_t REG_G3    = 4'b0011;
  localparam reg_code_t REG_G4    = 4'b0100;
  localparam reg_code_t REG_G5    = 4'b0101;
  localparam reg_code_t REG_G6    = 4'b0110;
  localparam reg_code_t REG_G7    = 4'b0111;
  localparam reg_code_t REG_PC    = 4'b1000;
  localparam reg_code_t REG_TEMP0 = 4'b1001;
  localparam reg_code_t REG_TEMP1 = 4'b1010;
  localparam reg_code_t REG_TEMP2 = 4'b1011;
  localparam reg_code_t REG_TEMP3 = 4'b1100;
  localparam reg_code_t REG_IR    = 4'b1101;

  // g0 is hard-wired zero and codes above IR are unmapped.
  function automatic logic reg_code_writable(input reg_code_t code);
    return (code != REG_G0) && (code <= REG_IR);
  endfunction

endpackage

// File: rtl/sc_reg_word.sv
// One bank register: async active-low reset to a per-instance value, loads d
// when load is high.
import sc_reg_bank_pkg::*;

module sc_reg_word #(
  parameter int                 WIDTH       = DEF_DATAWIDTH_BUS,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sc_reg_bank.sv
// Architectural register bank: g0-g7, PC, Temp0-Temp3, IR with one write port.
// PC fetch-advance is enabled by defining SC_REGBANK_PC_INC_EN.
import sc_reg_bank_pkg::*;

module sc_reg_bank #(
  parameter int                       DATAWIDTH_BUS           = DEF_DATAWIDTH_BUS,
  parameter int                       DATAWIDTH_REG_SELECTION = DEF_DATAWIDTH_REG_SELECTION,
  parameter logic [DATAWIDTH_BUS-1:0] PC_RESET_VALUE          = DEF_PC_RESET_VALUE,
  parameter logic [DATAWIDTH_BUS-1:0] PC_STEP                 = 4
) (
  input  logic                               SC_RegBANK_CLOCK_50,
  input  logic                               SC_RegBANK_RESET_InLow,
  input  logic                               SC_RegBANK_Write_In,
  input  logic [DATAWIDTH_REG_SELECTION-1:0] SC_RegBANK_WriteSel_In,
  input  logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_WriteData_In,
  input  logic                               SC_RegBANK_PcInc_In,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g0_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g1_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g2_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g3_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g4_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g5_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g6_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_g7_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_PC_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_Temp0_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_Temp1_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_Temp2_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_Temp3_Out,
  output logic [DATAWIDTH_BUS-1:0]           SC_RegBANK_IR_Out,
  output logic                               SC_RegBANK_WriteErr_Out
);

  localparam int FIRST_IDX = int'(REG_G1);
  localparam int LAST_IDX  = int'(REG_IR);
  localparam int PC_IDX    = int'(REG_PC);

  logic [DATAWIDTH_BUS-1:0] word_q [FIRST_IDX:LAST_IDX];
  logic [DATAWIDTH_BUS-1:0] word_d [FIRST_IDX:LAST_IDX];
  logic                     word_ld [FIRST_IDX:LAST_IDX];

  always_comb begin
    for (int c = FIRST_IDX; c <= LAST_IDX; c++) begin
      word_ld[c] = SC_RegBANK_Write_In &&
                   (SC_RegBANK_WriteSel_In == DATAWIDTH_REG_SELECTION'(c));
      word_d[c]  = SC_RegBANK_WriteData_In;
    end
`ifdef SC_REGBANK_PC_INC_EN
    // An explicit write to PC takes priority over the fetch advance.
    if (SC_RegBANK_PcInc_In && !word_ld[PC_IDX]) begin
      word_ld[PC_IDX] = 1'b1;
      word_d[PC_IDX]  = word_q[PC_IDX] + PC_STEP;
    end
`endif
  end

`ifndef SC_REGBANK_PC_INC_EN
  logic unused_pcinc;
  assign unused_pcinc = SC_RegBANK_PcInc_In ^ (|PC_STEP);
`endif

  for (genvar c = FIRST_IDX; c <= LAST_IDX; c++) begin : g_word
    localparam logic [DATAWIDTH_BUS-1:0] RV = (c == PC_IDX) ? PC_RESET_VALUE : '0;
    sc_reg_word #(
      .WIDTH       (DATAWIDTH_BUS),
      .RESET_VALUE (RV)
    ) u_word (
      .clk   (SC_RegBANK_CLOCK_50),
      .rst_n (SC_RegBANK_RESET_InLow),
      .load  (word_ld[c]),
      .d     (word_d[c]),
      .q     (word_q[c])
    );
  end

  always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
    if (!SC_RegBANK_RESET_InLow) begin
      SC_RegBANK_WriteErr_Out <= 1'b0;
    end else if (SC_RegBANK_Write_In) begin
      SC_RegBANK_WriteErr_Out <= !reg_code_writable(SC_RegBANK_WriteSel_In);
    end
  end

  assign SC_RegBANK_g0_Out    = '0;
  assign SC_RegBANK_g1_Out    = word_q[int'(REG_G1)];
  assign SC_RegBANK_g2_Out    = word_q[int'(REG_G2)];
  assign SC_RegBANK_g3_Out    = word_q[int'(REG_G3)];
  assign SC_RegBANK_g4_Out    = word_q[int'(REG_G4)];
  assign SC_RegBANK_g5_Out    = word_q[int'(REG_G5)];
  assign SC_RegBANK_g6_Out    = word_q[int'(REG_G6)];
  assign SC_RegBANK_g7_Out    = word_q[int'(REG_G7)];
  assign SC_RegBANK_PC_Out    = word_q[PC_IDX];
  assign SC_RegBANK_Temp0_Out = word_q[int'(REG_TEMP0)];
  assign SC_RegBANK_Temp1_Out = word_q[int'(REG_TEMP1)];
  assign SC_RegBANK_Temp2_Out = word_q[int'(REG_TEMP2)];
  assign SC_RegBANK_Temp3_Out = word_q[int'(REG_TEMP3)];
  assign SC_RegBANK_IR_Out    = word_q[LAST_IDX];

endmodule

// File: doc/sc_reg_bank.md
# sc_reg_bank

Architectural register bank for the 32-bit datapath: eight general registers g0–g7, PC, four temporaries Temp0–Temp3 and IR, all held in flops and presented in parallel to the bus-source multiplexer. A single write port, addressed with the same 4-bit register code the multiplexer uses, loads one register per cycle from the ALU/result bus. PC additionally supports a fetch-advance increment. The bank sits directly upstream of the source-select multiplexer and downstream of the ALU result bus.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, width of every register and bus
- DATAWIDTH_REG_SELECTION, 4, width of the write-address code
- PC_RESET_VALUE, 32'h0000_0000, PC value after reset
- PC_STEP, 4, increment applied to PC on SC_RegBANK_PcInc_In

Ports:
- SC_RegBANK_CLOCK_50  in  1  single clock, all state on rising edge
- SC_RegBANK_RESET_InLow  in  1  asynchronous, active-low reset
- SC_RegBANK_Write_In  in  1  write strobe for the write port
- SC_RegBANK_WriteSel_In  in  DATAWIDTH_REG_SELECTION  destination register code
- SC_RegBANK_WriteData_In  in  DATAWIDTH_BUS  write data
- SC_RegBANK_PcInc_In  in  1  PC += PC_STEP request
- SC_RegBANK_g0_Out … SC_RegBANK_g7_Out  out  DATAWIDTH_BUS each  general registers
- SC_RegBANK_PC_Out  out  DATAWIDTH_BUS  program counter
- SC_RegBANK_Temp0_Out … SC_RegBANK_Temp3_Out  out  DATAWIDTH_BUS each  temporaries
- SC_RegBANK_IR_Out  out  DATAWIDTH_BUS  instruction register
- SC_RegBANK_WriteErr_Out  out  1  registered flag: last strobed write hit an unmapped or read-only code

## Operation
- Register codes: 0000–0111 g0–g7; 1000 PC; 1001–1100 Temp0–Temp3; 1101 IR; 1110, 1111 unmapped.
- Reset (SC_RegBANK_RESET_InLow = 0, asynchronous): all registers 0 except PC = PC_RESET_VALUE; WriteErr = 0. Reset asserted mid-operation discards any in-flight write or increment immediately.
- Write: when Write_In = 1 at a rising edge, register addressed by WriteSel_In loads WriteData_In; all others hold.
- g0 is read-only zero: write to 0000 ignored, g0_Out stays 0, WriteErr set.
- Write to 1110/1111: no register changes, WriteErr set.
- WriteErr: updated only on cycles with Write_In = 1 (1 on ignored write, 0 on accepted write); holds otherwise.
- PC increment: PcInc_In = 1 loads PC + PC_STEP, modulo 2^DATAWIDTH_BUS (wraps FFFF_FFFC → 0000_0000, no flag).
- Simultaneous PcInc_In and write to PC (1000): explicit write wins, increment dropped. PcInc_In with a write to any other register: both take effect.
- No internal state machine beyond per-register load enables; bank is fully pipelined, one write per cycle, no back-pressure.

## Timing
- Write latency 1 cycle: data strobed at edge N is visible on the output from edge N onward (after clock-to-q); a combinational read in the cycle of the write returns the old value (no write-through bypass).
- PC increment latency 1 cycle; back-to-back PcInc_In advances PC by PC_STEP every cycle.
- All outputs driven directly from flops; no combinational input-to-output path.
- Inputs sampled only at rising edge; glitches between edges have no effect.

## Configuration
- SC_REGBANK_PC_INC_EN defined: PcInc_In and PC_STEP behave as above.
- Not defined: PcInc_In ignored (port retained, unconnected internally), PC changes only through the write port or reset.

## Structure
- Shared package: register-code constants (REG_G0 … REG_G7, REG_PC, REG_TEMP0 … REG_TEMP3, REG_IR), datawidth defaults, PC_RESET_VALUE default; same constants used by the source multiplexer and control unit.
- One sub-module: sc_reg_word — DATAWIDTH_BUS register with async active-low reset, parameterised reset value, load enable and load data; instantiated 13 times (g1–g7, PC, Temp0–Temp3, IR); g0 is a constant.
- Top level holds the write-address decoder, PC next-value mux (write / increment / hold) and WriteErr flop.

## Test plan
- Reset with PC_RESET_VALUE = 32'h0000_0800 → all outputs 0, PC_Out = 0000_0800, WriteErr = 0.
- Write 32'hDEAD_BEEF to 0011, then 32'h1234_5678 to 1011 on consecutive cycles → g3 = DEAD_BEEF after edge 1, Temp2 = 1234_5678 after edge 2, other registers unchanged, WriteErr = 0.
- Write 32'hFFFF_FFFF to 0000, then to 1111 → g0 stays 0, no register changes, WriteErr = 1 after each; next valid write to 0101 clears WriteErr.
- PC = FFFF_FFF8, PcInc_In high 3 cycles → PC FFFF_FFFC, 0000_0000, 0000_0004.
- Same cycle PcInc_In = 1 and write 32'h0000_0100 to 1000 → PC = 0000_0100; same cycle PcInc_In = 1 and write to 1101 → PC += 4 and IR loaded.
- Assert reset asynchronously mid-cycle while Write_In targets g7 → all outputs return to reset values before next edge; write not applied after release.
